decode_ctrl_stage: RTL and testbench
====================================

Name: decode_ctrl_stage

Overview:
- Registered, parametrised successor to the combinational main decoder.
- Sits between fetch and execute: accepts instructions over a valid/ready handshake and decodes them into the control bundle plus an illegal-instruction flag.
- Holds results in a 2-entry skid buffer so fetch never sees a combinational ready path from execute.
- Supports RV32 or RV64 memory sizes/word ops, and pipeline flush.

Parameters:
- XLEN, 32, datapath width; 64 enables LD/SD/LWU and OP-IMM-32/OP-32 decode.
- TRAP_ILLEGAL, 1, 1: bad opcode/funct3 raises out_illegal and zeroes side-effect controls; 0: treat as NOP with out_illegal=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered and incoming instructions
- in_valid  in  1  fetch has instruction
- in_ready  out  1  stage can accept (registered)
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  PC of decoded instruction
- out_instr  out  32  instruction pass-through (immediate generation downstream)
- out_memtoreg  out  1  load writes back memory data
- out_memwrite  out  1  store
- out_memsize  out  3  funct3 for loads/stores, else 0
- out_branch  out  1  conditional branch
- out_jump  out  1  JAL or JALR
- out_jalr  out  1  JALR (target from rs1)
- out_alusrc  out  2  REG=0, IMM=1, PC=2, NPC=3
- out_regwrite  out  1  writes rd
- out_wordop  out  1  RV64 32-bit op (opcodes 0x1B/0x3B); always 0 when XLEN=32
- out_illegal  out  1  undecodable instruction

Behaviour:
- Decode (combinational on in_instr, captured on accept); defaults are all 0, alusrc=REG. No latches.
  - AUIPC: alusrc=PC, regwrite.
  - LUI, OP-IMM: alusrc=IMM, regwrite.
  - OP: alusrc=REG, regwrite.
  - BRANCH: alusrc=REG, branch.
  - JAL/JALR: alusrc=NPC, jump, regwrite; jalr=1 for JALR.
  - LOAD: alusrc=IMM, regwrite, memtoreg, memsize=funct3.
  - STORE: alusrc=IMM, memwrite, memsize=funct3.
  - OP-IMM-32/OP-32 (XLEN=64 only): as OP-IMM/OP plus wordop.
  - FENCE/SYSTEM: all zero, legal.
- Illegal when:
  - opcode is unlisted, or in_instr[1:0]!=2'b11;
  - LOAD with funct3 in {7}, or in {3,6} when XLEN=32;
  - STORE with funct3 >= 3 (XLEN=32) or >= 4 (XLEN=64);
  - JALR with funct3!=0;
  - BRANCH with funct3 in {2,3}.
- If illegal and TRAP_ILLEGAL=1: regwrite=memwrite=branch=jump=0, illegal=1. The instruction still flows through so execute can trap.
- Buffer FSM states: EMPTY, ONE (output reg full), TWO (output + skid full).
  - in_ready = (state != TWO), registered.
  - accept = in_valid & in_ready; retire = out_valid & out_ready.
  - EMPTY: accept -> ONE.
  - ONE: accept & !retire -> TWO (new entry into skid); accept & retire -> ONE (output reg reloaded with new entry); retire only -> EMPTY.
  - TWO: retire -> ONE (skid moves to output reg); no accept possible.
- Latency: accept in cycle N -> out_valid in cycle N+1. Throughput 1/cycle with out_ready held high. Program order is strictly preserved.
- Output bundle is stable while out_valid & !out_ready.
- flush: next state EMPTY; out_valid=0 and in_ready=1 next cycle; an accept in the same cycle is discarded. flush overrides accept and retire.
- Reset (also mid-operation): next cycle state=EMPTY, out_valid=0, in_ready=1, all out_* control/data = 0. Reset overrides flush.

Test Plan:
- Reset, then in_instr=0x000000B7 (LUI x1), out_ready=1 -> next cycle out_valid=1, alusrc=1, regwrite=1, all other controls 0, out_pc=in_pc.
- 0x0000A103 (LW x2,0(x1)) -> memtoreg=1, regwrite=1, memsize=3'b010, alusrc=1. XLEN=32: 0x0020B023 (SD) -> illegal=1, memwrite=0. XLEN=64: same word gives memwrite=1, memsize=3'b011, illegal=0.
- out_ready=0, three back-to-back in_valid -> first two accepted, in_ready=0 from the third cycle. Raise out_ready -> bundles emerge in order 1,2,3 on consecutive cycles with no drops or duplicates.
- State TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1. The flushed and incoming instructions never appear.
- Assert rst mid-stream with state TWO -> next cycle out_valid=0, all outputs 0, in_ready=1. The first post-reset instruction decodes correctly.
- 0x00000000 and 0x0000707F (opcode 0x7F) with TRAP_ILLEGAL=1 -> illegal=1, regwrite=0. With TRAP_ILLEGAL=0 -> illegal=0, all controls 0.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
//   Registered decode stage between fetch and execute. Each accepted
//   instruction is decoded into the control bundle plus an illegal flag, then
//   held in a two-entry buffer (output register + skid register). Because
//   in_ready comes straight from the buffer state register, fetch never sees a
//   combinational path from out_ready.
//
// Parameters
//   XLEN         : 32 or 64. 64 adds LD/SD/LWU and the OP-IMM-32/OP-32 word ops.
//   TRAP_ILLEGAL : 1 = undecodable words flow through with out_illegal=1 and all
//                  controls cleared; 0 = they become a NOP with out_illegal=0.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop everything buffered plus any same-cycle accept
//   in_valid/in_ready, in_instr, in_pc        : fetch side handshake + payload
//   out_valid/out_ready, out_pc, out_instr    : execute side handshake + payload
//   out_memtoreg, out_memwrite, out_memsize, out_branch, out_jump, out_jalr,
//   out_alusrc (REG=0 IMM=1 PC=2 NPC=3), out_regwrite, out_wordop,
//   out_illegal   : decoded control bundle
// -----------------------------------------------------------------------------
module decode_ctrl_stage #(
    parameter int XLEN         = 32,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_memtoreg,
    output logic            out_memwrite,
    output logic [2:0]      out_memsize,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_jalr,
    output logic [1:0]      out_alusrc,
    output logic            out_regwrite,
    output logic            out_wordop,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_FENCE    = 7'h0F;
    localparam logic [6:0] OPC_OPIMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_OPIMM32  = 7'h1B;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_OP32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    localparam logic [1:0] SRC_REG = 2'd0;
    localparam logic [1:0] SRC_IMM = 2'd1;
    localparam logic [1:0] SRC_PC  = 2'd2;
    localparam logic [1:0] SRC_NPC = 2'd3;

    localparam bit IS64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            memtoreg;
        logic            memwrite;
        logic [2:0]      memsize;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [1:0]      alusrc;
        logic            regwrite;
        logic            wordop;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    // ------------------------------------------------------------------ decode
    bundle_t    dec;
    logic       bad;
    logic [2:0] f3;
    logic [2:0] store_lim;

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.instr  = in_instr;
        bad        = 1'b0;
        f3         = in_instr[14:12];
        store_lim  = IS64 ? 3'd4 : 3'd3;

        case (in_instr[6:0])
            OPC_LUI, OPC_OPIMM: begin
                dec.alusrc   = SRC_IMM;
                dec.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alusrc   = SRC_PC;
                dec.regwrite = 1'b1;
            end
            OPC_OP: begin
                dec.regwrite = 1'b1;
            end
            OPC_OPIMM32: begin
                if (IS64) begin
                    dec.alusrc   = SRC_IMM;
                    dec.regwrite = 1'b1;
                    dec.wordop   = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP32: begin
                if (IS64) begin
                    dec.regwrite = 1'b1;
                    dec.wordop   = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                bad        = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_JAL: begin
                dec.alusrc   = SRC_NPC;
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_JALR: begin
                dec.alusrc   = SRC_NPC;
                dec.jump     = 1'b1;
                dec.jalr     = 1'b1;
                dec.regwrite = 1'b1;
                bad          = (f3 != 3'd0);
            end
            OPC_LOAD: begin
                dec.alusrc   = SRC_IMM;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
                dec.memsize  = f3;
                // LD (3) and LWU (6) only exist on RV64
                bad = (f3 == 3'd7) || (!IS64 && ((f3 == 3'd3) || (f3 == 3'd6)));
            end
            OPC_STORE: begin
                dec.alusrc   = SRC_IMM;
                dec.memwrite = 1'b1;
                dec.memsize  = f3;
                bad          = (f3 >= store_lim);
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // legal, no controls
            end
            default: bad = 1'b1;
        endcase

        if (in_instr[1:0] != 2'b11) bad = 1'b1;

        // A bad word keeps its pc/instr so execute can still trap on it, but
        // carries no controls; only the flag depends on TRAP_ILLEGAL.
        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.instr   = in_instr;
            dec.illegal = TRAP_ILLEGAL;
        end
    end

    // ------------------------------------------------------------------ buffer
    state_t  state_q, state_d;
    bundle_t out_q, skid_q;
    logic    accept, retire;
    logic    ld_out_new, ld_out_skid, ld_skid;

    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ld_out_new  = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    ld_out_new = 1'b1;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && retire) begin
                    ld_out_new = 1'b1;
                end else if (accept) begin
                    ld_skid = 1'b1;
                    state_d = S_TWO;
                end else if (retire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so the only event is a retire
                if (retire) begin
                    ld_out_skid = 1'b1;
                    state_d     = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d     = S_EMPTY;
            ld_out_new  = 1'b0;
            ld_out_skid = 1'b0;
            ld_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (ld_out_new)       out_q <= dec;
            else if (ld_out_skid) out_q <= skid_q;
            if (ld_skid)          skid_q <= dec;
        end
    end

    assign out_pc       = out_q.pc;
    assign out_instr    = out_q.instr;
    assign out_memtoreg = out_q.memtoreg;
    assign out_memwrite = out_q.memwrite;
    assign out_memsize  = out_q.memsize;
    assign out_branch   = out_q.branch;
    assign out_jump     = out_q.jump;
    assign out_jalr     = out_q.jalr;
    assign out_alusrc   = out_q.alusrc;
    assign out_regwrite = out_q.regwrite;
    assign out_wordop   = out_q.wordop;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage. Two instances share all inputs:
//   u32: XLEN=32, TRAP_ILLEGAL=1      u64: XLEN=64, TRAP_ILLEGAL=0
// A queue-based reference of the buffer plus a table-style decode model
// supply every expected value.
module tb_decode_ctrl_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        memtoreg;
        logic        memwrite;
        logic [2:0]  memsize;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic [1:0]  alusrc;
        logic        regwrite;
        logic        wordop;
        logic        illegal;
    } bun_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        rdy32, vld32, mtr32, mw32, br32, j32, jr32, rw32, wo32, il32;
    logic [31:0] pc32, ins32;
    logic [2:0]  ms32;
    logic [1:0]  src32;
    logic        rdy64, vld64, mtr64, mw64, br64, j64, jr64, rw64, wo64, il64;
    logic [63:0] pc64;
    logic [31:0] ins64;
    logic [2:0]  ms64;
    logic [1:0]  src64;

    decode_ctrl_stage #(.XLEN(32), .TRAP_ILLEGAL(1'b1)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld32), .out_ready(out_ready),
        .out_pc(pc32), .out_instr(ins32), .out_memtoreg(mtr32), .out_memwrite(mw32),
        .out_memsize(ms32), .out_branch(br32), .out_jump(j32), .out_jalr(jr32),
        .out_alusrc(src32), .out_regwrite(rw32), .out_wordop(wo32), .out_illegal(il32));

    decode_ctrl_stage #(.XLEN(64), .TRAP_ILLEGAL(1'b0)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld64), .out_ready(out_ready),
        .out_pc(pc64), .out_instr(ins64), .out_memtoreg(mtr64), .out_memwrite(mw64),
        .out_memsize(ms64), .out_branch(br64), .out_jump(j64), .out_jalr(jr64),
        .out_alusrc(src64), .out_regwrite(rw64), .out_wordop(wo64), .out_illegal(il64));

    bun_t o32, o64;
    assign o32 = {32'b0, pc32, ins32, mtr32, mw32, ms32, br32, j32, jr32, src32, rw32, wo32, il32};
    assign o64 = {pc64, ins64, mtr64, mw64, ms64, br64, j64, jr64, src64, rw64, wo64, il64};

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t q[$];

    // Decode rules as a table: per-opcode controls, then the set of funct3
    // values allowed for that opcode as an 8-bit mask.
    function automatic bun_t model(ent_t e, bit is64, bit trap);
        bun_t       b;
        bit         ok;
        logic [7:0] okset;
        logic [6:0] opc;
        logic [2:0] f3;
        opc   = e.instr[6:0];
        f3    = e.instr[14:12];
        b     = '0;
        b.pc  = is64 ? e.pc : {32'b0, e.pc[31:0]};
        b.instr = e.instr;
        ok    = 1'b1;
        okset = 8'hFF;
        case (opc)
            7'h37, 7'h13: begin b.alusrc = 2'd1; b.regwrite = 1'b1; end
            7'h17:        begin b.alusrc = 2'd2; b.regwrite = 1'b1; end
            7'h33:        begin b.regwrite = 1'b1; end
            7'h1B:        begin b.alusrc = 2'd1; b.regwrite = 1'b1; b.wordop = 1'b1; ok = is64; end
            7'h3B:        begin b.regwrite = 1'b1; b.wordop = 1'b1; ok = is64; end
            7'h63:        begin b.branch = 1'b1; okset = 8'hF3; end
            7'h6F:        begin b.alusrc = 2'd3; b.jump = 1'b1; b.regwrite = 1'b1; end
            7'h67:        begin b.alusrc = 2'd3; b.jump = 1'b1; b.jalr = 1'b1; b.regwrite = 1'b1; okset = 8'h01; end
            7'h03:        begin b.alusrc = 2'd1; b.regwrite = 1'b1; b.memtoreg = 1'b1; b.memsize = f3;
                                okset = is64 ? 8'h7F : 8'h37; end
            7'h23:        begin b.alusrc = 2'd1; b.memwrite = 1'b1; b.memsize = f3;
                                okset = is64 ? 8'h0F : 8'h07; end
            7'h0F, 7'h73: ;
            default:      ok = 1'b0;
        endcase
        ok = ok && okset[f3];
        if (!ok) begin
            b.memtoreg = 0; b.memwrite = 0; b.memsize = 0; b.branch = 0; b.jump = 0;
            b.jalr = 0; b.alusrc = 0; b.regwrite = 0; b.wordop = 0;
            b.illegal = trap;
        end
        return b;
    endfunction

    // Fields not pinned down for a trapped word are ignored in comparisons.
    function automatic bun_t care(bun_t b);
        bun_t r;
        r = b;
        if (r.illegal) begin
            r.memtoreg = 0; r.memsize = 0; r.jalr = 0; r.alusrc = 0; r.wordop = 0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opcs [13];
        int          k;
        opcs = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h63,
                 7'h6F, 7'h67, 7'h03, 7'h23, 7'h0F, 7'h73};
        r = $urandom();
        k = $urandom_range(0, 15);
        if (k < 13) r[6:0] = opcs[k];
        return r;
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [31:0] a, b;
        a = $urandom();
        b = $urandom();
        return {a, b[31:2], 2'b00};
    endfunction

    // One clock with the current inputs; the reference queue follows it.
    task automatic step();
        bit acc, ret;
        acc = in_valid && (q.size() < 2);
        ret = out_ready && (q.size() > 0);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) q.push_back(ent_t'({in_instr, in_pc}));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
        step(); step();
        rst = 0;
        n_cmp++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b1 || o32 !== '0) begin
            n_bad++; $display("FAIL reset32: vld=%b rdy=%b out=%h, want 0 1 0", vld32, rdy32, o32);
        end
        n_cmp++;
        if (vld64 !== 1'b0 || rdy64 !== 1'b1 || o64 !== '0) begin
            n_bad++; $display("FAIL reset64: vld=%b rdy=%b out=%h, want 0 1 0", vld64, rdy64, o64);
        end
    endtask

    task automatic test_decode();
        logic [31:0] words [12];
        ent_t        e;
        bun_t        x32, x64;
        words = '{32'h000000B7, 32'h0000A103, 32'h0020B023, 32'h00000000, 32'h0000707F,
                  32'h00008067, 32'h0000006F, 32'h00209463, 32'h0000A463, 32'h00000017,
                  32'h0010809B, 32'h0000E103};
        out_ready = 1;
        foreach (words[i]) begin
            in_valid = 1; in_instr = words[i]; in_pc = rand_pc();
            e = ent_t'({in_instr, in_pc});
            step();
            in_valid = 0;
            x32 = model(e, 1'b0, 1'b1);
            x64 = model(e, 1'b1, 1'b0);
            n_cmp++;
            if (vld32 !== 1'b1 || care(o32) !== care(x32)) begin
                n_bad++; $display("FAIL decode32 %h: vld=%b out=%h, want 1 %h", words[i], vld32, o32, x32);
            end
            n_cmp++;
            if (vld64 !== 1'b1 || o64 !== x64) begin
                n_bad++; $display("FAIL decode64 %h: vld=%b out=%h, want 1 %h", words[i], vld64, o64, x64);
            end
            if (words[i] == 32'h000000B7) begin
                n_cmp++;
                if (src32 !== 2'd1 || rw32 !== 1'b1 || mtr32 !== 1'b0 || mw32 !== 1'b0 || j32 !== 1'b0 ||
                    br32 !== 1'b0 || il32 !== 1'b0 || pc32 !== e.pc[31:0]) begin
                    n_bad++; $display("FAIL lui: src=%0d rw=%b il=%b pc=%h, want 1 1 0 %h", src32, rw32, il32, pc32, e.pc[31:0]);
                end
            end
            if (words[i] == 32'h0020B023) begin
                n_cmp++;
                if (il32 !== 1'b1 || mw32 !== 1'b0) begin
                    n_bad++; $display("FAIL sd32: il=%b mw=%b, want 1 0", il32, mw32);
                end
                n_cmp++;
                if (il64 !== 1'b0 || mw64 !== 1'b1 || ms64 !== 3'b011) begin
                    n_bad++; $display("FAIL sd64: il=%b mw=%b ms=%b, want 0 1 011", il64, mw64, ms64);
                end
            end
            if (words[i] == 32'h00000000 || words[i] == 32'h0000707F) begin
                n_cmp++;
                if (il32 !== 1'b1 || rw32 !== 1'b0) begin
                    n_bad++; $display("FAIL trap32 %h: il=%b rw=%b, want 1 0", words[i], il32, rw32);
                end
                n_cmp++;
                if (il64 !== 1'b0 || {mtr64, mw64, ms64, br64, j64, jr64, src64, rw64, wo64} !== '0) begin
                    n_bad++; $display("FAIL nop64 %h: il=%b ctl=%b, want all 0", words[i], il64,
                                      {mtr64, mw64, ms64, br64, j64, jr64, src64, rw64, wo64});
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        ent_t e [3];
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdy32 !== (i < 2) || rdy64 !== (i < 2)) begin
                n_bad++; $display("FAIL b2b_ready %0d: rdy=%b/%b, want %b", i, rdy32, rdy64, i < 2);
            end
            if (i > 0) begin
                n_cmp++;
                if (vld32 !== 1'b1 || ins32 !== e[0].instr || ins64 !== e[0].instr) begin
                    n_bad++; $display("FAIL b2b_hold %0d: vld=%b ins=%h, want 1 %h", i, vld32, ins32, e[0].instr);
                end
            end
            in_valid = 1; in_instr = rand_instr(); in_pc = rand_pc();
            e[i] = ent_t'({in_instr, in_pc});
            step();
        end
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (vld32 !== 1'b1 || care(o32) !== care(model(e[k], 1'b0, 1'b1)) ||
                vld64 !== 1'b1 || o64 !== model(e[k], 1'b1, 1'b0)) begin
                n_bad++; $display("FAIL b2b_order %0d: vld=%b ins=%h/%h, want %h", k, vld32, ins32, ins64, e[k].instr);
            end
            step();
            if (k == 1) in_valid = 0;
        end
        n_cmp++;
        if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_drain: vld=%b/%b ins=%h, want 0", vld32, vld64, ins32);
        end
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_instr = rand_instr(); in_pc = rand_pc();
            step();
        end
        flush = 1; in_instr = 32'h00000013; in_pc = rand_pc();
        step();
        flush = 0; in_valid = 0;
        n_cmp++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b1 || vld64 !== 1'b0 || rdy64 !== 1'b1) begin
            n_bad++; $display("FAIL flush: vld=%b/%b rdy=%b/%b, want 0 1", vld32, vld64, rdy32, rdy64);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
                n_bad++; $display("FAIL flush_ghost %0d: vld=%b/%b ins=%h, want 0", i, vld32, vld64, ins32);
            end
        end
    endtask

    task automatic test_reset_mid();
        ent_t e;
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_instr = rand_instr(); in_pc = rand_pc();
            step();
        end
        n_cmp++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
            n_bad++; $display("FAIL full_before_rst: rdy=%b/%b, want 0", rdy32, rdy64);
        end
        rst = 1; flush = 1;
        step();
        rst = 0; flush = 0; in_valid = 0;
        n_cmp++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b1 || o32 !== '0 || vld64 !== 1'b0 || rdy64 !== 1'b1 || o64 !== '0) begin
            n_bad++; $display("FAIL rst_mid: vld=%b/%b rdy=%b/%b out=%h/%h, want 0 1 0",
                              vld32, vld64, rdy32, rdy64, o32, o64);
        end
        in_valid = 1; out_ready = 1; in_instr = 32'h0000A103; in_pc = rand_pc();
        e = ent_t'({in_instr, in_pc});
        step();
        in_valid = 0;
        n_cmp++;
        if (vld32 !== 1'b1 || care(o32) !== care(model(e, 1'b0, 1'b1)) || ms32 !== 3'b010 ||
            mtr32 !== 1'b1 || rw32 !== 1'b1 || src32 !== 2'd1 || o64 !== model(e, 1'b1, 1'b0)) begin
            n_bad++; $display("FAIL post_rst_lw: vld=%b out=%h, want 1 %h", vld32, o32, model(e, 1'b0, 1'b1));
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            n_cmp++;
            if (vld32 !== (q.size() > 0) || rdy32 !== (q.size() < 2) ||
                vld64 !== (q.size() > 0) || rdy64 !== (q.size() < 2)) begin
                n_bad++; $display("FAIL rnd_hs cyc%0d: vld=%b/%b rdy=%b/%b, want occupancy %0d",
                                  c, vld32, vld64, rdy32, rdy64, q.size());
            end
            if (q.size() > 0) begin
                n_cmp++;
                if (care(o32) !== care(model(q[0], 1'b0, 1'b1))) begin
                    n_bad++; $display("FAIL rnd32 cyc%0d: out=%h, want %h", c, o32, model(q[0], 1'b0, 1'b1));
                end
                n_cmp++;
                if (o64 !== model(q[0], 1'b1, 1'b0)) begin
                    n_bad++; $display("FAIL rnd64 cyc%0d: out=%h, want %h", c, o64, model(q[0], 1'b1, 1'b0));
                end
            end
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = rand_pc();
            step();
        end
        flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
